seg_shift_receiver: RTL and testbench

//  Receiving end of the 7-segment serial link (sclk/rclk/ser, 74HC595-style).

---
 rtl/seg_shift_receiver_pkg.sv | 12 +
 rtl/sync_rise.sv | 29 ++
 rtl/seg_shift_receiver.sv | 114 +++++++++++
 tb/tb_seg_shift_receiver.sv | 177 +++++++++++++++++
 4 files changed

// File: rtl/seg_shift_receiver_pkg.sv
// rtl/seg_shift_receiver_pkg.sv - shared segment-link encodings and frame constants
package seg_shift_receiver_pkg;

   typedef enum logic {
      HUNT = 1'b0,
      RECV = 1'b1
   } seg_rx_state_t;

   localparam int SEG_FRAME_BITS = 48;
   localparam int SEG_TIMEOUT    = 4096;

endpackage

// File: rtl/sync_rise.sv
// rtl/sync_rise.sv - 2-FF synchroniser plus history flop with rising-edge detect
module sync_rise (
   input  logic clk_i,
   input  logic rst_ni,
   input  logic d_i,
   output logic level_o,
   output logic rise_o
);

   logic meta_q;
   logic sync_q;
   logic hist_q;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         meta_q <= 1'b0;
         sync_q <= 1'b0;
         hist_q <= 1'b0;
      end else begin
         meta_q <= d_i;
         sync_q <= meta_q;
         hist_q <= sync_q;
      end
   end

   assign level_o = sync_q;
   assign rise_o  = sync_q & ~hist_q;

endmodule

// File: rtl/seg_shift_receiver.sv
// rtl/seg_shift_receiver.sv - receive side of the 595-style segment link with frame checking
module seg_shift_receiver
   import seg_shift_receiver_pkg::*;
#(
   parameter int WIDTH      = SEG_FRAME_BITS,
   parameter int INVERT_SER = 1,
   parameter int TIMEOUT    = SEG_TIMEOUT,
   parameter int ERRW       = 8
) (
   input  logic             eclk,
   input  logic             ereset_n,
   input  logic             sclk,
   input  logic             rclk,
   input  logic             ser,
   output logic [WIDTH-1:0] data_out,
   output logic             data_valid,
   output logic             frame_err,
   output logic [ERRW-1:0]  err_count,
   output logic             synced
);

   localparam int BW = $clog2(WIDTH + 2);
   localparam int IW = $clog2(TIMEOUT);
   localparam logic [BW-1:0] FULL_CNT = BW'(WIDTH);
   localparam logic [BW-1:0] SAT_CNT  = BW'(WIDTH + 1);
   localparam logic [IW-1:0] IDLE_MAX = IW'(TIMEOUT - 1);

   logic sclk_rise, rclk_rise, ser_s;
   logic unused_sclk_lvl, unused_rclk_lvl, unused_ser_rise;

   sync_rise u_sync_sclk (.clk_i(eclk), .rst_ni(ereset_n), .d_i(sclk),
                          .level_o(unused_sclk_lvl), .rise_o(sclk_rise));
   sync_rise u_sync_rclk (.clk_i(eclk), .rst_ni(ereset_n), .d_i(rclk),
                          .level_o(unused_rclk_lvl), .rise_o(rclk_rise));
   sync_rise u_sync_ser  (.clk_i(eclk), .rst_ni(ereset_n), .d_i(ser),
                          .level_o(ser_s), .rise_o(unused_ser_rise));

   seg_rx_state_t    state_q, state_d;
   logic [WIDTH-1:0] shreg_q, shreg_d;
   logic [BW-1:0]    bitcnt_q, bitcnt_d;
   logic [IW-1:0]    idle_q, idle_d;
   logic [WIDTH-1:0] data_q, data_d;
   logic             valid_q, valid_d;
   logic             ferr_q, ferr_d;
   logic [ERRW-1:0]  errcnt_q, errcnt_d;
   logic             synced_q, synced_d;

   always_comb begin
      state_d  = state_q;
      shreg_d  = shreg_q;
      bitcnt_d = bitcnt_q;
      data_d   = data_q;
      valid_d  = 1'b0;
      ferr_d   = 1'b0;
      errcnt_d = errcnt_q;
      synced_d = (state_q == RECV);
      idle_d   = (state_q == RECV && !sclk_rise) ? idle_q + 1'b1 : '0;

      if (sclk_rise) begin
         shreg_d = {shreg_q[WIDTH-2:0], ser_s};
         if (bitcnt_q != SAT_CNT) bitcnt_d = bitcnt_q + 1'b1;
      end

      // A coincident sclk rise latches the pre-shift word; its bit opens the next frame.
      if (rclk_rise) begin
         bitcnt_d = sclk_rise ? BW'(1) : '0;
         if (state_q == HUNT) begin
            state_d = RECV;
         end else if (bitcnt_q == FULL_CNT) begin
            data_d  = (INVERT_SER != 0) ? ~shreg_q : shreg_q;
            valid_d = 1'b1;
         end else begin
            ferr_d = 1'b1;
            if (errcnt_q != '1) errcnt_d = errcnt_q + 1'b1;
         end
      end else if (state_q == RECV && !sclk_rise && idle_q == IDLE_MAX) begin
         state_d  = HUNT;
         bitcnt_d = '0;
      end

      if (state_d != state_q) idle_d = '0;
   end

   always_ff @(posedge eclk or negedge ereset_n) begin
      if (!ereset_n) begin
         state_q  <= HUNT;
         shreg_q  <= '0;
         bitcnt_q <= '0;
         idle_q   <= '0;
         data_q   <= '0;
         valid_q  <= 1'b0;
         ferr_q   <= 1'b0;
         errcnt_q <= '0;
         synced_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         shreg_q  <= shreg_d;
         bitcnt_q <= bitcnt_d;
         idle_q   <= idle_d;
         data_q   <= data_d;
         valid_q  <= valid_d;
         ferr_q   <= ferr_d;
         errcnt_q <= errcnt_d;
         synced_q <= synced_d;
      end
   end

   assign data_out   = data_q;
   assign data_valid = valid_q;
   assign frame_err  = ferr_q;
   assign err_count  = errcnt_q;
   assign synced     = synced_q;

endmodule

// File: tb/tb_seg_shift_receiver.sv
// tb/tb_seg_shift_receiver.sv - scoreboard and table-driven bench for seg_shift_receiver
module tb_seg_shift_receiver;

   logic        eclk = 1'b0;
   logic        ereset_n = 1'b0;
   logic        sclk = 1'b0;
   logic        rclk = 1'b0;
   logic        ser = 1'b0;
   logic [47:0] data_out;
   logic        data_valid;
   logic        frame_err;
   logic [7:0]  err_count;
   logic        synced;

   seg_shift_receiver #(.WIDTH(48), .INVERT_SER(1), .TIMEOUT(4096), .ERRW(8)) dut (
      .eclk(eclk), .ereset_n(ereset_n), .sclk(sclk), .rclk(rclk), .ser(ser),
      .data_out(data_out), .data_valid(data_valid), .frame_err(frame_err),
      .err_count(err_count), .synced(synced)
   );

   always #5 eclk = ~eclk;

   typedef struct {
      logic        err;
      logic [47:0] data;
      logic [7:0]  cnt;
   } exp_t;

   typedef struct {
      logic [47:0] data;
      int          nbits;
   } vec_t;

   exp_t        sbq[$];
   vec_t        tbl[6];
   int          n_pass = 0;
   int          n_total = 0;
   logic [7:0]  exp_err = 8'h00;
   logic [47:0] exp_data = 48'h0;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
   endtask

   task automatic cyc(input int n);
      repeat (n) @(posedge eclk);
      #1;
   endtask

   // The link carries active-low segments, so every data bit goes out inverted.
   task automatic send_bit(input logic b, input logic with_rclk);
      ser = ~b;
      cyc(3);
      sclk = 1'b1;
      if (with_rclk) rclk = 1'b1;
      cyc(4);
      sclk = 1'b0;
      rclk = 1'b0;
      cyc(3);
   endtask

   task automatic send_bits(input logic [63:0] v, input int n);
      for (int i = n - 1; i >= 0; i--) send_bit(v[i], 1'b0);
   endtask

   task automatic pulse_rclk();
      rclk = 1'b1;
      cyc(4);
      rclk = 1'b0;
      cyc(6);
   endtask

   task automatic push_good(input logic [47:0] d);
      exp_data = d;
      sbq.push_back('{err: 1'b0, data: d, cnt: exp_err});
   endtask

   task automatic push_err();
      if (exp_err != 8'hFF) exp_err = exp_err + 8'h01;
      sbq.push_back('{err: 1'b1, data: exp_data, cnt: exp_err});
   endtask

   always @(negedge eclk) begin : monitor
      exp_t e;
      if (ereset_n === 1'b1 && (data_valid || frame_err)) begin
         chk("pulse_exclusive", 64'(data_valid & frame_err), 64'd0);
         if (sbq.size() == 0) begin
            chk("unexpected_pulse", 64'({data_valid, frame_err}), 64'd0);
         end else begin
            e = sbq.pop_front();
            chk("pulse_kind", 64'(frame_err), 64'(e.err));
            chk("data_out", 64'(data_out), 64'(e.data));
            chk("err_count", 64'(err_count), 64'(e.cnt));
         end
      end
   end

   initial begin
      tbl[0] = '{data: 48'h0A1B2C3D4E5F, nbits: 47};
      tbl[1] = '{data: 48'h123456789ABC, nbits: 50};
      tbl[2] = '{data: 48'hFEDCBA987654, nbits: 48};
      tbl[3] = '{data: 48'hFFFFFFFFFFFF, nbits: 48};
      tbl[4] = '{data: 48'h000000000000, nbits: 48};
      tbl[5] = '{data: 48'h800000000001, nbits: 48};

      cyc(3);
      chk("rst_data_out", 64'(data_out), 64'd0);
      chk("rst_valid", 64'(data_valid), 64'd0);
      chk("rst_ferr", 64'(frame_err), 64'd0);
      chk("rst_err_count", 64'(err_count), 64'd0);
      chk("rst_synced", 64'(synced), 64'd0);
      ereset_n = 1'b1;
      cyc(3);

      pulse_rclk();
      chk("synced_after_align", 64'(synced), 64'd1);
      send_bits(64'h0A1B2C3D4E5F, 48);
      push_good(48'h0A1B2C3D4E5F);
      pulse_rclk();
      chk("first_frame", 64'(data_out), 64'h0A1B2C3D4E5F);

      for (int i = 0; i < 6; i++) begin
         send_bits(64'(tbl[i].data), tbl[i].nbits);
         if (tbl[i].nbits == 48) push_good(tbl[i].data);
         else push_err();
         pulse_rclk();
         if (i == 1) chk("err_count_after_bad", 64'(err_count), 64'd2);
      end

      send_bits(64'h13579BDF2468, 48);
      push_good(48'h13579BDF2468);
      send_bit(1'b1, 1'b1);
      cyc(6);
      send_bits(64'h0ACE12345678, 47);
      push_good(48'h8ACE12345678);
      pulse_rclk();
      chk("coincident_follow", 64'(data_out), 64'h8ACE12345678);

      cyc(4200);
      chk("synced_timeout", 64'(synced), 64'd0);
      pulse_rclk();
      chk("synced_realign", 64'(synced), 64'd1);
      send_bits(64'hC0FFEE123456, 48);
      push_good(48'hC0FFEE123456);
      pulse_rclk();

      send_bits(64'hDEADBEEF0000, 20);
      ereset_n = 1'b0;
      #1;
      chk("midrst_data_out", 64'(data_out), 64'd0);
      chk("midrst_valid", 64'(data_valid), 64'd0);
      chk("midrst_ferr", 64'(frame_err), 64'd0);
      chk("midrst_err_count", 64'(err_count), 64'd0);
      chk("midrst_synced", 64'(synced), 64'd0);
      chk("pending_before_reset", 64'(sbq.size()), 64'd0);
      sbq.delete();
      exp_err = 8'h00;
      exp_data = 48'h0;
      cyc(3);
      ereset_n = 1'b1;
      cyc(3);
      pulse_rclk();
      for (int i = 0; i < 300; i++) begin
         push_err();
         pulse_rclk();
      end
      cyc(6);
      chk("err_count_saturated", 64'(err_count), 64'hFF);
      chk("pending_at_end", 64'(sbq.size()), 64'd0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
